lfsr_sym_checker: RTL and testbench
===================================

LFSR_SYM_CHECKER -- requirements
Module: lfsr_sym_checker

Interface
REQ-001 SHALL have parameter MAX_DLY, default 15, maximum channel delay in symbol strobes searched.
REQ-002 SHALL have parameter LOCK_CNT, default 32, consecutive matches required to declare lock.
REQ-003 SHALL have parameter LOSS_WIN, default 64, strobes per loss-detection window.
REQ-004 SHALL have parameter LOSS_THR, default 8, errors within one window that force loss of lock.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clk_en  input  1  symbol strobe; sym_in is valid in that cycle.
REQ-008 SHALL have port sym_in  input  4  received payload symbol.
REQ-009 SHALL have port clr_cnt  input  1  synchronous clear of err_count and sym_count.
REQ-010 SHALL have port locked  output  1  high while in LOCKED.
REQ-011 SHALL have port dly_sel  output  4  current candidate or locked delay.
REQ-012 SHALL have port sym_err  output  1  one-cycle pulse per mismatched symbol while locked.
REQ-013 SHALL have port err_count  output  32  saturating count of locked-state symbol errors.
REQ-014 SHALL have port sym_count  output  32  saturating count of locked-state symbols checked.

Function
REQ-015 SHALL contain a local 22-bit LFSR (21-bit s plus feedback bit fb) that advances only on clk_en: s[i] <= s[i-1] ^ (TAPS[i-1] & fb) for i = 1..20, s[0] <= fb, fb <= s[20].
REQ-016 SHALL load s = LFSR_SEED, fb = 0 at reset; expected symbol = {s[0], s[3], s[4], s[1]}, captured before the advance.
REQ-017 SHALL push each expected symbol into a MAX_DLY+1 deep delay line on clk_en; tap d holds the symbol generated d strobes earlier.
REQ-018 SHALL compare sym_in against delay-line tap dly_sel only on clk_en cycles.
REQ-019 SHALL implement states FILL, SEARCH and LOCKED.
REQ-020 FILL: SHALL count MAX_DLY+1 strobes, then move to SEARCH with dly_sel = 0 and match run = 0.
REQ-021 SEARCH, match: run += 1; SHALL enter LOCKED on the strobe where run reaches LOCK_CNT.
REQ-022 SEARCH, mismatch: run <= 0; dly_sel increments and SHALL wrap from MAX_DLY to 0.
REQ-023 LOCKED: SHALL increment sym_count on every strobe, and on mismatch pulse sym_err and increment err_count.
REQ-024 LOCKED: SHALL count strobes and errors per LOSS_WIN window; on error number LOSS_THR within a window, go to SEARCH with dly_sel unchanged and run = 0.
REQ-025 A window counter reaching LOSS_WIN SHALL clear both window counters on that strobe.
REQ-026 All outputs SHALL be registered; compare results SHALL appear on the cycle after the strobe.
REQ-027 err_count and sym_count SHALL hold at 0xFFFFFFFF, never wrap.
REQ-028 clr_cnt SHALL take priority over a simultaneous increment, giving 0, not 1.
REQ-029 FILL and SEARCH SHALL NOT update the counters or pulse sym_err.
REQ-030 With clk_en low, SHALL hold all state; sym_err low.

Reset
REQ-031 reset_n low SHALL asynchronously force state FILL, LFSR to seed, delay line to 0, dly_sel = 0, locked = 0, sym_err = 0, err_count = 0, sym_count = 0, all internal counters to 0.
REQ-032 Reset during LOCKED SHALL drop locked immediately; reacquisition restarts from FILL.

Structure
REQ-033 The shared package/defines SHALL hold LFSR_LEN (22), LFSR_SEED, the TAPS table and the state encoding.
REQ-034 The local generator SHALL be sub-module lfsr_ref_gen (clk, reset_n, clk_en, sym_out[3:0]).

Verification
REQ-035 Transmitter-identical stream, delay 0, no errors -> locked rises after 16 + 32 strobes (+1 cycle), dly_sel = 0, err_count = 0.
REQ-036 Delay 5 -> locked with dly_sel = 5; sym_count increases by 1 per strobe.
REQ-037 Delay 15 after a loss at dly_sel 15 with mismatch -> dly_sel wraps to 0, then relocks at 15.
REQ-038 One flipped symbol while locked -> single sym_err pulse, err_count = 1, locked stays 1.
REQ-039 8 errors within 64 strobes -> locked falls after the 8th error; clr_cnt coincident with an error -> err_count = 0.
REQ-040 reset_n asserted mid-LOCKED -> all outputs 0 asynchronously; after release, lock reacquired per REQ-035.

Source files
------------

// File: rtl/lfsr_sym_checker_pkg.sv
// Shared constants for the PRBS symbol checker: generator length, seed, feedback taps, FSM encoding.
package lfsr_sym_checker_pkg;

  localparam int LFSR_LEN = 22;
  localparam int S_LEN    = LFSR_LEN - 1;

  localparam logic [S_LEN-1:0] LFSR_SEED = 21'h15A3C7;
  // Single tap into bit 1 gives x^22 + x + 1, a primitive polynomial.
  localparam logic [S_LEN-2:0] TAPS      = 20'h00001;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [3:0] sym_of(input logic [S_LEN-1:0] s);
    return {s[0], s[3], s[4], s[1]};
  endfunction

endpackage

// File: rtl/lfsr_sym_checker_ref_gen.sv
// Local reference PRBS generator; sym_out is the symbol for the current strobe (combinational from state).
// Advances one step per clk_en; no backpressure, holds when clk_en is low.
module lfsr_ref_gen
  import lfsr_sym_checker_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  output logic [3:0] sym_out
);

  logic [S_LEN-1:0] s;
  logic             fb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s  <= LFSR_SEED;
      fb <= 1'b0;
    end else if (clk_en) begin
      s  <= {s[S_LEN-2:0] ^ (TAPS & {(S_LEN-1){fb}}), fb};
      fb <= s[S_LEN-1];
    end
  end

  assign sym_out = sym_of(s);

endmodule

// File: rtl/lfsr_sym_checker.sv
// PRBS symbol checker: searches channel delay, locks, counts errors, drops lock on error bursts.
// Results registered one cycle after each clk_en strobe; no backpressure, idles when clk_en is low.
module lfsr_sym_checker
  import lfsr_sym_checker_pkg::*;
#(
  parameter int MAX_DLY  = 15,
  parameter int LOCK_CNT = 32,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [3:0]  sym_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic [3:0]  dly_sel,
  output logic        sym_err,
  output logic [31:0] err_count,
  output logic [31:0] sym_count
);

  localparam int FW = $clog2(MAX_DLY + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_THR + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(MAX_DLY);
  localparam logic [3:0]    DLY_LAST  = 4'(MAX_DLY);
  localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WIN - 1);
  localparam logic [EW-1:0] THR_LAST  = EW'(LOSS_THR - 1);

  state_t        state, state_n;
  logic [FW-1:0] fill_cnt, fill_n;
  logic [RW-1:0] run, run_n;
  logic [WW-1:0] win_strb, ws_n;
  logic [EW-1:0] win_err, we_n;
  logic [3:0]    dly_n;
  logic          sym_err_n, err_inc, sym_inc;
  logic [3:0]    gen_sym, exp_sym;
  logic          mismatch;
  logic [3:0]    dl [1:MAX_DLY];

  lfsr_ref_gen u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .sym_out (gen_sym)
  );

  // Tap 0 is the symbol generated on this strobe; tap d is d strobes older.
  always_comb begin
    exp_sym = gen_sym;
    for (int d = 1; d <= MAX_DLY; d++) begin
      if (dly_sel == 4'(d)) exp_sym = dl[d];
    end
  end

  assign mismatch = (sym_in != exp_sym);

  always_comb begin
    state_n   = state;
    dly_n     = dly_sel;
    run_n     = run;
    fill_n    = fill_cnt;
    ws_n      = win_strb;
    we_n      = win_err;
    sym_err_n = 1'b0;
    err_inc   = 1'b0;
    sym_inc   = 1'b0;
    if (clk_en) begin
      unique case (state)
        ST_FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state_n = ST_SEARCH;
            fill_n  = '0;
            dly_n   = '0;
            run_n   = '0;
          end else begin
            fill_n = fill_cnt + 1'b1;
          end
        end
        ST_SEARCH: begin
          if (mismatch) begin
            run_n = '0;
            dly_n = (dly_sel == DLY_LAST) ? 4'd0 : dly_sel + 4'd1;
          end else if (run == RUN_LAST) begin
            state_n = ST_LOCKED;
            run_n   = '0;
            ws_n    = '0;
            we_n    = '0;
          end else begin
            run_n = run + 1'b1;
          end
        end
        ST_LOCKED: begin
          sym_inc = 1'b1;
          ws_n    = win_strb + 1'b1;
          if (mismatch) begin
            err_inc   = 1'b1;
            sym_err_n = 1'b1;
            we_n      = win_err + 1'b1;
          end
          // Loss wins over a window rollover landing on the same strobe.
          if (mismatch && win_err == THR_LAST) begin
            state_n = ST_SEARCH;
            run_n   = '0;
            ws_n    = '0;
            we_n    = '0;
          end else if (win_strb == WIN_LAST) begin
            ws_n = '0;
            we_n = '0;
          end
        end
        default: state_n = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FILL;
      fill_cnt  <= '0;
      run       <= '0;
      win_strb  <= '0;
      win_err   <= '0;
      dly_sel   <= '0;
      locked    <= 1'b0;
      sym_err   <= 1'b0;
      err_count <= '0;
      sym_count <= '0;
      for (int d = 1; d <= MAX_DLY; d++) dl[d] <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_n;
      run      <= run_n;
      win_strb <= ws_n;
      win_err  <= we_n;
      dly_sel  <= dly_n;
      locked   <= (state_n == ST_LOCKED);
      sym_err  <= sym_err_n;
      if (clk_en) begin
        dl[1] <= gen_sym;
        for (int d = 2; d <= MAX_DLY; d++) dl[d] <= dl[d-1];
      end
      if (clr_cnt) err_count <= '0;
      else if (err_inc && err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      if (clr_cnt) sym_count <= '0;
      else if (sym_inc && sym_count != 32'hFFFF_FFFF) sym_count <= sym_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_lfsr_sym_checker.sv
// Scoreboarded bench for lfsr_sym_checker: a procedural model queues expected outputs per cycle.
module tb_lfsr_sym_checker;
  import lfsr_sym_checker_pkg::*;

  localparam int MAX_DLY  = 15;
  localparam int LOCK_CNT = 32;
  localparam int LOSS_WIN = 64;
  localparam int LOSS_THR = 8;
  localparam int NSEQ     = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [3:0]  sym_in = 4'h0;
  logic        locked;
  logic [3:0]  dly_sel;
  logic        sym_err;
  logic [31:0] err_count;
  logic [31:0] sym_count;

  always #5 clk = ~clk;

  lfsr_sym_checker #(
    .MAX_DLY  (MAX_DLY),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_WIN (LOSS_WIN),
    .LOSS_THR (LOSS_THR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .sym_in    (sym_in),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .dly_sel   (dly_sel),
    .sym_err   (sym_err),
    .err_count (err_count),
    .sym_count (sym_count)
  );

  typedef logic [69:0] obs_t;   // {locked, dly_sel, sym_err, err_count, sym_count}
  obs_t       exp_q[$];
  logic [3:0] gseq [0:NSEQ-1];
  int         n_chk = 0;
  int         n_pass = 0;

  int          m_state, m_k, m_fill, m_run, m_ws, m_we;
  logic [3:0]  m_dly;
  logic        m_se;
  logic [31:0] m_err, m_sym;

  function automatic obs_t observed();
    return {locked, dly_sel, sym_err, err_count, sym_count};
  endfunction

  function automatic logic [3:0] sym_for(input int d);
    return (m_k >= d) ? gseq[m_k - d] : 4'h0;
  endfunction

  task automatic build_seq();
    logic [20:0] s, ns;
    logic [19:0] taps;
    logic        fb;
    s = LFSR_SEED; taps = TAPS; fb = 1'b0;
    for (int k = 0; k < NSEQ; k++) begin
      gseq[k] = {s[0], s[3], s[4], s[1]};
      ns[0] = fb;
      for (int i = 1; i <= 20; i++) ns[i] = s[i-1] ^ (taps[i-1] & fb);
      fb = s[20];
      s  = ns;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_fill = 0; m_run = 0; m_ws = 0; m_we = 0;
    m_dly = 4'd0; m_se = 1'b0; m_err = 32'd0; m_sym = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic en, input logic [3:0] sym, input logic clr);
    logic [3:0] tap;
    logic       mis, inc_e, inc_s;
    m_se = 1'b0; inc_e = 1'b0; inc_s = 1'b0;
    if (en) begin
      tap = (m_k >= int'(m_dly)) ? gseq[m_k - int'(m_dly)] : 4'h0;
      mis = (sym != tap);
      if (m_state == 0) begin
        m_fill++;
        if (m_fill == MAX_DLY + 1) begin m_state = 1; m_fill = 0; m_dly = 4'd0; m_run = 0; end
      end else if (m_state == 1) begin
        if (mis) begin
          m_run = 0;
          m_dly = (m_dly == 4'(MAX_DLY)) ? 4'd0 : m_dly + 4'd1;
        end else begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_state = 2; m_run = 0; m_ws = 0; m_we = 0; end
        end
      end else begin
        inc_s = 1'b1;
        m_ws++;
        if (mis) begin inc_e = 1'b1; m_se = 1'b1; m_we++; end
        if (mis && m_we == LOSS_THR) begin m_state = 1; m_run = 0; m_ws = 0; m_we = 0; end
        else if (m_ws == LOSS_WIN) begin m_ws = 0; m_we = 0; end
      end
      m_k++;
    end
    if (clr) m_err = 32'd0;
    else if (inc_e && m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
    if (clr) m_sym = 32'd0;
    else if (inc_s && m_sym != 32'hFFFF_FFFF) m_sym = m_sym + 32'd1;
    exp_q.push_back({m_state == 2, m_dly, m_se, m_err, m_sym});
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic drive(input logic en, input logic [3:0] sym, input logic clr);
    clk_en = en; sym_in = sym; clr_cnt = clr;
    model_step(en, sym, clr);
    @(negedge clk);
    clk_en = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t obs, ex;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (observed() !== '0) $display("FAIL reset_outputs: dut=%h expected=0", observed());
    else n_pass++;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'($urandom), c == 1);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL reset_idle cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
    end
  endtask

  task automatic test_lock_d0(input string name);
    obs_t obs, ex;
    int   lock_at;
    lock_at = -1;
    for (int c = 0; c < 70; c++) begin
      if (c % 9 == 4) drive(1'b0, 4'($urandom), 1'b0);
      else            drive(1'b1, sym_for(0), 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL %s_sb cycle %0d: dut=%h expected=%h", name, c, obs, ex);
      else n_pass++;
      if (locked === 1'b1 && lock_at < 0) lock_at = m_k;
    end
    n_chk++;
    if (lock_at !== 48) $display("FAIL %s_latency: locked after %0d strobes, expected 48", name, lock_at);
    else n_pass++;
    n_chk++;
    if ({locked, dly_sel, err_count} !== {1'b1, 4'd0, 32'd0})
      $display("FAIL %s_final: locked=%b dly=%0d err=%0d expected 1/0/0", name, locked, dly_sel, err_count);
    else n_pass++;
  endtask

  task automatic test_loss_clr();
    obs_t obs, ex;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, (c % 2 == 0 && c <= 14) ? sym_for(0) ^ 4'h5 : sym_for(0), c == 4);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL loss_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
      if (c == 4) begin
        n_chk++;
        if (err_count !== 32'd0) $display("FAIL clr_priority: err_count=%0d expected 0", err_count);
        else n_pass++;
      end
      if (c == 12) begin
        n_chk++;
        if (locked !== 1'b1) $display("FAIL loss_7th_err: locked=%b expected 1", locked);
        else n_pass++;
      end
      if (c == 14) begin
        n_chk++;
        if ({locked, dly_sel, err_count} !== {1'b0, 4'd0, 32'd5})
          $display("FAIL loss_8th_err: locked=%b dly=%0d err=%0d expected 0/0/5", locked, dly_sel, err_count);
        else n_pass++;
      end
    end
  endtask

  task automatic test_delay5();
    obs_t obs, ex;
    int   lock_at;
    lock_at = -1;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, sym_for(5), 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL delay5_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
      if (locked === 1'b1 && lock_at < 0) lock_at = m_k;
    end
    n_chk++;
    if ({locked, dly_sel} !== {1'b1, 4'd5}) $display("FAIL delay5_lock: locked=%b dly=%0d expected 1/5", locked, dly_sel);
    else n_pass++;
    n_chk++;
    if (lock_at < 0 || sym_count !== 32'(m_k - lock_at))
      $display("FAIL delay5_symcount: sym_count=%0d expected %0d", sym_count, m_k - lock_at);
    else n_pass++;
  endtask

  task automatic test_single_err();
    obs_t obs, ex;
    int   pulses;
    logic dropped;
    pulses = 0; dropped = 1'b0;
    for (int c = 0; c < 80; c++) begin
      drive(1'b1, (c == 3) ? sym_for(5) ^ 4'h8 : sym_for(5), 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL single_err_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
      if (sym_err === 1'b1) pulses++;
      if (locked !== 1'b1) dropped = 1'b1;
    end
    n_chk++;
    if (pulses !== 1 || err_count !== 32'd1 || dropped !== 1'b0)
      $display("FAIL single_err: pulses=%0d err=%0d dropped=%b expected 1/1/0", pulses, err_count, dropped);
    else n_pass++;
  endtask

  task automatic test_wrap_d15();
    obs_t obs, ex;
    do_reset();
    for (int c = 0; c < 200 && locked !== 1'b1; c++) begin
      drive(1'b1, sym_for(15), 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL d15_acq_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
    end
    n_chk++;
    if ({locked, dly_sel} !== {1'b1, 4'd15}) $display("FAIL d15_lock: locked=%b dly=%0d expected 1/15", locked, dly_sel);
    else n_pass++;
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, sym_for(15) ^ 4'h3, 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL d15_err_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
      if (c == 7) begin
        n_chk++;
        if ({locked, dly_sel} !== {1'b0, 4'd15}) $display("FAIL d15_loss: locked=%b dly=%0d expected 0/15", locked, dly_sel);
        else n_pass++;
      end
      if (c == 8) begin
        n_chk++;
        if (dly_sel !== 4'd0) $display("FAIL d15_wrap: dly=%0d expected 0", dly_sel);
        else n_pass++;
      end
    end
    for (int c = 0; c < 150 && locked !== 1'b1; c++) begin
      drive(1'b1, sym_for(15), 1'b0);
      obs = observed(); ex = exp_q.pop_front(); n_chk++;
      if (obs !== ex) $display("FAIL d15_relock_sb cycle %0d: dut=%h expected=%h", c, obs, ex);
      else n_pass++;
    end
    n_chk++;
    if ({locked, dly_sel} !== {1'b1, 4'd15}) $display("FAIL d15_relock: locked=%b dly=%0d expected 1/15", locked, dly_sel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (observed() !== '0) $display("FAIL async_reset: dut=%h expected=0", observed());
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_lock_d0("relock");
  endtask

  initial begin
    build_seq();
    test_reset();
    test_lock_d0("lock_d0");
    test_loss_clr();
    test_delay5();
    test_single_err();
    test_wrap_d15();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
